// File: rtl/maindec_mc_stall_if.sv
// Controller-side bundle for maindec_mc_stall: opcode/memory handshake in, datapath controls out.
// Perf counter fields exist only when MAINDEC_PERF_CNT_EN is defined.
interface maindec_mc_stall_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             mem_req;
   logic             pcwrite;
   logic             memwrite;
   logic             irwrite;
   logic             regwrite;
   logic             alusrca;
   logic             branch;
   logic             iord;
   logic             branch_ne;
   logic             immzero;
   logic [1:0]       regdst;
   logic [1:0]       memtoreg;
   logic [1:0]       alusrcb;
   logic [1:0]       pcsrc;
   logic [2:0]       aluop;
   logic             error;
   logic [4:0]       state_o;
`ifdef MAINDEC_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] instr_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      input  opcode, mem_ready,
      output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
             branch_ne, immzero, regdst, memtoreg, alusrcb, pcsrc, aluop, error, state_o,
             cyc_cnt, instr_cnt, stall_cnt
   );
   modport slave (
      output opcode, mem_ready,
      input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
             branch_ne, immzero, regdst, memtoreg, alusrcb, pcsrc, aluop, error, state_o,
             cyc_cnt, instr_cnt, stall_cnt
   );
`else
   modport master (
      input  opcode, mem_ready,
      output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
             branch_ne, immzero, regdst, memtoreg, alusrcb, pcsrc, aluop, error, state_o
   );
   modport slave (
      output opcode, mem_ready,
      input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
             branch_ne, immzero, regdst, memtoreg, alusrcb, pcsrc, aluop, error, state_o
   );
`endif
endinterface

// File: rtl/maindec_mc_stall.sv
// Multicycle MIPS main controller with mem_ready stall, wait timeout into ERROR and
// optional saturating perf counters (MAINDEC_PERF_CNT_EN).
module maindec_mc_stall #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               reset,
   maindec_mc_stall_if.master bus
);
   typedef enum logic [4:0] {
      S_FETCH   = 5'd0,
      S_DECODE  = 5'd1,
      S_MEMADR  = 5'd2,
      S_MEMRD   = 5'd3,
      S_MEMWB   = 5'd4,
      S_MEMWR   = 5'd5,
      S_RTYPEEX = 5'd6,
      S_RTYPEWB = 5'd7,
      S_BEQEX   = 5'd8,
      S_BNEEX   = 5'd9,
      S_ADDIEX  = 5'd10,
      S_ANDIEX  = 5'd11,
      S_ORIEX   = 5'd12,
      S_SLTIEX  = 5'd13,
      S_IWB     = 5'd14,
      S_JEX     = 5'd15,
      S_JALEX   = 5'd16,
      S_ERROR   = 5'd31
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              in_wait;
   logic              timeout;

   assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   // mem_ready in the same cycle always beats the timeout
   assign timeout = TIMEOUT_EN && in_wait && !bus.mem_ready && (wait_q == WAIT_MAX);

   always_comb begin
      state_d = S_ERROR;
      case (state_q)
         S_FETCH:   state_d = bus.mem_ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_BNE:       state_d = S_BNEEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ANDI:      state_d = S_ANDIEX;
               OP_ORI:       state_d = S_ORIEX;
               OP_SLTI:      state_d = S_SLTIEX;
               OP_J:         state_d = S_JEX;
               OP_JAL:       state_d = S_JALEX;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : (timeout ? S_ERROR : S_MEMRD);
         S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : (timeout ? S_ERROR : S_MEMWR);
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: state_d = S_IWB;
         S_MEMWB, S_RTYPEWB, S_IWB, S_BEQEX, S_BNEEX, S_JEX, S_JALEX: state_d = S_FETCH;
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_ERROR;
      endcase
   end

   // Counter tracks one uninterrupted stall; any state change restarts it
   always_comb begin
      wait_d = '0;
      if (in_wait && !bus.mem_ready && (state_d == state_q)) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      bus.mem_req   = 1'b0;
      bus.pcwrite   = 1'b0;
      bus.memwrite  = 1'b0;
      bus.irwrite   = 1'b0;
      bus.regwrite  = 1'b0;
      bus.alusrca   = 1'b0;
      bus.branch    = 1'b0;
      bus.iord      = 1'b0;
      bus.branch_ne = 1'b0;
      bus.immzero   = 1'b0;
      bus.regdst    = 2'b00;
      bus.memtoreg  = 2'b00;
      bus.alusrcb   = 2'b00;
      bus.pcsrc     = 2'b00;
      bus.aluop     = 3'b000;
      case (state_q)
         S_FETCH: begin
            // IR/PC load only on the completing cycle so a stalled fetch advances PC once
            bus.mem_req = 1'b1;
            bus.alusrcb = 2'b01;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
         end
         S_DECODE: bus.alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         S_MEMRD: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
         end
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 2'b01;
         end
         S_RTYPEEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 3'b010;
         end
         S_RTYPEWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 2'b01;
         end
         S_BEQEX, S_BNEEX: begin
            bus.alusrca   = 1'b1;
            bus.aluop     = 3'b001;
            bus.pcsrc     = 2'b01;
            bus.branch    = (state_q == S_BEQEX);
            bus.branch_ne = (state_q == S_BNEEX);
         end
         S_ANDIEX, S_ORIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.immzero = 1'b1;
            bus.aluop   = (state_q == S_ANDIEX) ? 3'b011 : 3'b100;
         end
         S_SLTIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.aluop   = 3'b101;
         end
         S_IWB: bus.regwrite = 1'b1;
         S_JEX: begin
            bus.pcsrc   = 2'b10;
            bus.pcwrite = 1'b1;
         end
         S_JALEX: begin
            bus.pcsrc    = 2'b10;
            bus.pcwrite  = 1'b1;
            bus.regwrite = 1'b1;
            bus.regdst   = 2'b10;
            bus.memtoreg = 2'b10;
         end
         default: ;
      endcase
   end

   assign bus.error   = (state_q == S_ERROR);
   assign bus.state_o = state_q;

`ifdef MAINDEC_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      cyc_cnt_d   = cyc_cnt_q;
      instr_cnt_d = instr_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if ((state_q != S_ERROR) && (cyc_cnt_q != '1)) begin
         cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
      // Only completing states can hand control back to FETCH
      if ((state_d == S_FETCH) && (state_q != S_FETCH) && (instr_cnt_q != '1)) begin
         instr_cnt_d = instr_cnt_q + 1'b1;
      end
      if (in_wait && !bus.mem_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt_q   <= '0;
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         instr_cnt_q <= instr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.cyc_cnt   = cyc_cnt_q;
   assign bus.instr_cnt = instr_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
